// File: rtl/xaddr_decoder_bus.sv
// Registered address decoder: maps CPU accesses onto N_SLV handshaked slave channels,
// trapping unmapped addresses and slave timeouts with a sticky flag, cause, address and count.
//
// state  | meaning
// IDLE   | waiting for sel; decodes addr and latches the access
// ACCESS | slave selected, waiting for its ready or the timeout limit
// RESP   | one-cycle acknowledge with captured read data
// TRAP   | one-cycle acknowledge of a faulted access, data forced to 0
module xaddr_decoder_bus #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int N_SLV = 4,
  parameter logic [N_SLV*ADDR_W-1:0] BASE_VEC = {12'h420, 12'h410, 12'h400, 12'h000},
  parameter logic [N_SLV*4-1:0] OFFW_VEC = {4'd0, 4'd0, 4'd4, 4'd10},
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  output logic                    ready,
  output logic [DATA_W-1:0]       data_to_rd,
  output logic [N_SLV-1:0]        slv_sel,
  input  logic [N_SLV-1:0]        slv_ready,
  input  logic [N_SLV*DATA_W-1:0] slv_data_to_rd,
  input  logic                    trap_clr,
  output logic                    trap_pend,
  output logic                    trap_cause,
  output logic [ADDR_W-1:0]       trap_addr,
  output logic [7:0]              trap_cnt
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, TRAP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         wcnt;
  logic [DATA_W-1:0]  data_q;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [ADDR_W-1:0]  mask;
  logic               sel_ready;
  logic               timeout_hit;
  logic               trap_set;
  logic [DATA_W-1:0]  slot_data;

  // Scan from the top so the lowest hitting index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    mask    = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      mask = {ADDR_W{1'b1}} << OFFW_VEC[i*4 +: 4];
      if ((addr & mask) == BASE_VEC[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ready   = slv_ready[idx_q];
  assign timeout_hit = (wcnt == 8'(TIMEOUT - 1));
  assign slot_data   = slv_data_to_rd[int'(idx_q)*DATA_W +: DATA_W];
  assign trap_set    = (state_nxt == TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel) begin
          state_nxt = hit ? ACCESS : TRAP;
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          state_nxt = TRAP;
        end
      end
      RESP:    state_nxt = IDLE;
      TRAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state == RESP) || (state == TRAP);
    data_to_rd = (state == RESP) ? data_q : '0;
    slv_sel    = '0;
    if (state == ACCESS) begin
      slv_sel[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wcnt   <= '0;
      data_q <= '0;
    end else begin
      if (state == IDLE && sel) begin
        addr_q <= addr;
        we_q   <= we;
        idx_q  <= hit_idx;
        wcnt   <= '0;
      end
      if (state == ACCESS) begin
        if (sel_ready) begin
          data_q <= we_q ? '0 : slot_data;
        end else if (!timeout_hit) begin
          wcnt <= wcnt + 8'd1;
        end
      end
    end
  end

  // Trap bookkeeping is done on entry so the flags are already visible while ready is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pend  <= 1'b0;
      trap_cause <= 1'b0;
      trap_addr  <= '0;
      trap_cnt   <= '0;
    end else if (trap_set) begin
      trap_pend  <= 1'b1;
      trap_cause <= (state == ACCESS);
      trap_addr  <= (state == IDLE) ? addr : addr_q;
      if (trap_cnt != 8'hff) begin
        trap_cnt <= trap_cnt + 8'd1;
      end
    end else if (trap_clr) begin
      trap_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xaddr_decoder_bus.sv
// Directed bench for xaddr_decoder_bus: a scoreboard queue holds expected read data,
// popped whenever the DUT acknowledges; trap state and selects are checked inline.
module tb_xaddr_decoder_bus;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic         we;
  logic [11:0]  addr;
  logic         ready;
  logic [31:0]  data_to_rd;
  logic [3:0]   slv_sel;
  logic [3:0]   slv_ready;
  logic [127:0] slv_data_to_rd;
  logic         trap_clr;
  logic         trap_pend;
  logic         trap_cause;
  logic [11:0]  trap_addr;
  logic [7:0]   trap_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] slot_val[4];

  xaddr_decoder_bus dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .addr(addr),
    .ready(ready), .data_to_rd(data_to_rd), .slv_sel(slv_sel),
    .slv_ready(slv_ready), .slv_data_to_rd(slv_data_to_rd),
    .trap_clr(trap_clr), .trap_pend(trap_pend), .trap_cause(trap_cause),
    .trap_addr(trap_addr), .trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL rdata_unexpected: observed %0h expected no response", data_to_rd);
        end else begin
          chk("rdata", {32'd0, data_to_rd}, {32'd0, exp_q.pop_front()});
        end
      end else begin
        chk("rdata_idle_zero", {32'd0, data_to_rd}, 64'd0);
      end
    end
  end

  // Mapped access; returns the cycle number in which ready was observed.
  task automatic run_access(input logic [11:0] a, input logic w, input int idx,
                            input int waits, input logic [3:0] stray, output int rc);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    slv_data_to_rd = {slot_val[3], slot_val[2], slot_val[1], slot_val[0]};
    sel = 1'b1;
    addr = a;
    we = w;
    slv_ready = stray & ~onehot;
    tick();
    for (int i = 0; i < waits; i++) begin
      chk("acc_wait_sel", {60'd0, slv_sel}, {60'd0, onehot});
      chk("acc_wait_ready", {63'd0, ready}, 64'd0);
      tick();
    end
    chk("acc_sel", {60'd0, slv_sel}, {60'd0, onehot});
    chk("acc_ready_low", {63'd0, ready}, 64'd0);
    slv_ready = stray | onehot;
    exp_q.push_back(w ? 32'd0 : slot_val[idx]);
    tick();
    chk("resp_ready", {63'd0, ready}, 64'd1);
    chk("resp_sel", {60'd0, slv_sel}, 64'd0);
    rc = cyc;
    sel = 1'b0;
    slv_ready = 4'b0000;
    tick();
  endtask

  task automatic run_unmapped(input logic [11:0] a, input logic clr, input logic verbose);
    sel = 1'b1;
    addr = a;
    we = 1'b0;
    trap_clr = clr;
    exp_q.push_back(32'd0);
    tick();
    trap_clr = 1'b0;
    if (exp_cnt < 255) exp_cnt++;
    if (verbose) begin
      chk("unm_ready", {63'd0, ready}, 64'd1);
      chk("unm_sel", {60'd0, slv_sel}, 64'd0);
      chk("unm_pend", {63'd0, trap_pend}, 64'd1);
      chk("unm_cause", {63'd0, trap_cause}, 64'd0);
      chk("unm_addr", {52'd0, trap_addr}, {52'd0, a});
    end
    chk("unm_cnt", {56'd0, trap_cnt}, exp_cnt);
    sel = 1'b0;
    tick();
  endtask

  initial begin
    int rc1;
    int rc2;
    slot_val[0] = 32'hDEADBEEF;
    slot_val[1] = 32'h1111_1111;
    slot_val[2] = 32'hCAFE_0002;
    slot_val[3] = 32'h3333_3333;
    rst_n = 1'b0;
    sel = 1'b0;
    we = 1'b0;
    addr = '0;
    slv_ready = '0;
    slv_data_to_rd = '0;
    trap_clr = 1'b0;
    tick();
    tick();
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_sel", {60'd0, slv_sel}, 64'd0);
    chk("rst_data", {32'd0, data_to_rd}, 64'd0);
    chk("rst_trap", {50'd0, trap_pend, trap_cause, trap_addr}, 64'd0);
    chk("rst_cnt", {56'd0, trap_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: zero-wait read from slot 0
    run_access(12'h005, 1'b0, 0, 0, 4'b0000, rc1);
    chk("t1_pend", {63'd0, trap_pend}, 64'd0);

    // 2: write with 3 waits, then back-to-back read to slot 2
    run_access(12'h40F, 1'b1, 1, 3, 4'b0000, rc1);
    run_access(12'h410, 1'b0, 2, 0, 4'b0000, rc2);
    chk("t2_b2b_gap", rc2 - rc1, 64'd3);

    // 3: unmapped
    run_unmapped(12'h800, 1'b0, 1'b1);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("t3_clr_pend", {63'd0, trap_pend}, 64'd0);
    chk("t3_clr_cnt", {56'd0, trap_cnt}, exp_cnt);

    // 4: timeout on slot 3 with stray ready from slot 0
    sel = 1'b1;
    addr = 12'h420;
    we = 1'b0;
    slv_ready = 4'b0001;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("t4_sel", {60'd0, slv_sel}, 64'h8);
      chk("t4_ready_low", {63'd0, ready}, 64'd0);
      if (i == 14) exp_q.push_back(32'd0);
      tick();
    end
    exp_cnt++;
    chk("t4_ready", {63'd0, ready}, 64'd1);
    chk("t4_pend", {63'd0, trap_pend}, 64'd1);
    chk("t4_cause", {63'd0, trap_cause}, 64'd1);
    chk("t4_addr", {52'd0, trap_addr}, 64'h420);
    chk("t4_cnt", {56'd0, trap_cnt}, exp_cnt);
    sel = 1'b0;
    slv_ready = 4'b0000;
    tick();
    run_access(12'h420, 1'b0, 3, 14, 4'b0001, rc1);
    chk("t4v_cnt", {56'd0, trap_cnt}, exp_cnt);

    // 5: set wins over clear, clear alone, saturation
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("t5_pre_clr", {63'd0, trap_pend}, 64'd0);
    run_unmapped(12'hFFF, 1'b1, 1'b1);
    chk("t5_set_wins", {63'd0, trap_pend}, 64'd1);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("t5_clr", {63'd0, trap_pend}, 64'd0);
    chk("t5_clr_cnt", {56'd0, trap_cnt}, exp_cnt);
    for (int i = 0; i < 300; i++) begin
      run_unmapped(12'h800 + 12'(i), 1'b0, 1'b0);
    end
    chk("t5_sat", {56'd0, trap_cnt}, 64'd255);

    // 6: async reset mid-ACCESS
    sel = 1'b1;
    addr = 12'h005;
    we = 1'b0;
    slv_ready = 4'b0000;
    tick();
    chk("t6_sel_before", {60'd0, slv_sel}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_sel_async", {60'd0, slv_sel}, 64'd0);
    chk("t6_ready", {63'd0, ready}, 64'd0);
    chk("t6_trap", {50'd0, trap_pend, trap_cause, trap_addr}, 64'd0);
    chk("t6_cnt", {56'd0, trap_cnt}, 64'd0);
    sel = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    run_access(12'h3FC, 1'b0, 0, 1, 4'b0000, rc1);
    run_unmapped(12'h430, 1'b0, 1'b1);

    tick();
    chk("sb_empty", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xaddr_decoder_bus.md
Name: xaddr_decoder_bus

Overview:
Parametrised, registered successor to the fixed-peripheral address decoder. It decodes CPU accesses onto N_SLV slave channels. Each channel has a base address and offset width, both set as parameters. Every access is a handshake: select the slave, wait for it to be ready, return read data, then acknowledge the CPU. Unmapped accesses and slave timeouts raise a sticky trap, and the faulting address is captured. The block sits between the CPU data port and the memory, register file, LED, switch, button and ext slaves.

Parameters:
ADDR_W, 12, address width
DATA_W, 32, data width
N_SLV, 4, number of slave channels (1..16)
BASE_VEC, {12'h420,12'h410,12'h400,12'h000}, packed N_SLV*ADDR_W base addresses; slot i = bits [i*ADDR_W +: ADDR_W]
OFFW_VEC, {4'd0,4'd0,4'd4,4'd10}, packed N_SLV*4 offset widths; slot i = bits [i*4 +: 4]
TIMEOUT, 15, max wait cycles in ACCESS before trap (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous and active-low
sel  in  1  CPU access request
we  in  1  CPU write (1) / read (0)
addr  in  ADDR_W  CPU address
ready  out  1  one-cycle access acknowledge
data_to_rd  out  DATA_W  read data, valid while ready=1
slv_sel  out  N_SLV  one-hot slave select
slv_ready  in  N_SLV  per-slave ready
slv_data_to_rd  in  N_SLV*DATA_W  packed slave read data; slot i = [i*DATA_W +: DATA_W]
trap_clr  in  1  clears trap_pend
trap_pend  out  1  sticky trap flag
trap_cause  out  1  0 = unmapped, 1 = timeout
trap_addr  out  ADDR_W  address of the last trap
trap_cnt  out  8  saturating trap count

Behaviour:
- Decode: hit_i = ((addr & ~((1<<OFFW_i)-1)) == BASE_i). The lowest hitting index wins. No hit means unmapped.
- FSM states: IDLE, ACCESS, RESP, TRAP.
- IDLE: sel is sampled only here. When sel=1, latch addr, we and the decoded index.
  - On a hit, go to ACCESS and clear wcnt.
  - With no hit, go to TRAP with cause=0.
- ACCESS: slv_sel[idx]=1 and all other bits are 0. slv_ready from non-selected slaves is ignored.
  - If slv_ready[idx]=1, capture slot idx into the data register (or 0 when we=1) and go to RESP.
  - Otherwise wcnt increments. When wcnt==TIMEOUT-1 and ready is still low, go to TRAP with cause=1.
  - If ready arrives in the same cycle as the timeout limit, ready wins.
- RESP: ready=1 and data_to_rd = captured data. Next state is IDLE.
- TRAP: ready=1 and data_to_rd=0.
  - trap_pend←1; trap_cause and trap_addr are updated.
  - trap_cnt increments and saturates at 255.
  - Next state is IDLE.
- Latency:
  - Zero-wait slave: sel sampled at edge 0, ACCESS cycle 1, ready=1 in cycle 2.
  - Each slave wait cycle adds one cycle.
  - Unmapped access: ready=1 in cycle 1.
- Master holds sel/addr/we stable until ready. The master deasserts sel or presents the next access the cycle after ready; back-to-back accesses are allowed.
- ready and data_to_rd are registered-state outputs, so there is no combinational path from addr to ready.
- trap_clr=1 clears trap_pend. If a TRAP entry happens in the same cycle, set wins. trap_addr, trap_cause and trap_cnt are unaffected by trap_clr.
- Reset (async, any state, including mid-ACCESS): state=IDLE, and all outputs, wcnt, trap_pend, trap_cause, trap_addr and trap_cnt go to 0. slv_sel drops immediately.
- data_to_rd is 0 in all states other than RESP.

Test Plan:
1. Read at 0x005, slv_ready[0]=1 immediately, slot0=0xDEADBEEF -> slv_sel=0001 for 1 cycle; ready=1 with data 0xDEADBEEF 2 cycles after sel; trap_pend=0.
2. Write at 0x40F, slave 1 ready after 3 wait cycles -> slv_sel=0010 for 4 cycles; ready=1 with data 0; then read 0x410 back-to-back -> slv_sel=0100, and no idle-cycle loss beyond the IDLE sample.
3. Read at 0x800 (unmapped) -> no slv_sel bit ever set; ready=1 one cycle after sel; data 0; trap_pend=1, cause=0, trap_addr=0x800, trap_cnt=1.
4. Read at 0x420 with slv_ready[3] held 0 and slv_ready[0]=1 -> after 15 ACCESS cycles, TRAP with cause=1, trap_addr=0x420; stray ready from slave 0 is ignored. Variant: ready at cycle 15 -> normal RESP, no trap.
5. Trap with trap_clr asserted in the same cycle -> trap_pend=1. trap_clr alone later -> trap_pend=0 while trap_cnt is unchanged. 300 unmapped accesses -> trap_cnt=255.
6. rst_n low for 1 cycle mid-ACCESS -> slv_sel=0 asynchronously; all outputs 0; the next access decodes normally.
